ps2_kbd_ctrl: RTL and testbench
===============================

PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

Interface
REQ-001 Parameter: DEPTH, 8, event FIFO entries (power of two, 2..16).
REQ-002 clk  in  1  system clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  one-cycle strobe: in_byte holds a received PS/2 scancode byte.
REQ-005 in_byte  in  8  received byte; sampled only when in_valid=1.
REQ-006 ev_pop  in  1  consumer acknowledges the head event this cycle.
REQ-007 clr_err  in  1  clears the sticky overflow and proto_err flags.
REQ-008 ev_valid  out  1  FIFO non-empty; head event presented.
REQ-009 ev_code  out  8  head event scancode (prefixes stripped).
REQ-010 ev_ext  out  1  head event carried an E0 prefix.
REQ-011 ev_break  out  1  head event is a release (F0 seen).
REQ-012 ev_count  out  5  number of events in FIFO (0..DEPTH).
REQ-013 overflow  out  1  sticky: an event was dropped because the FIFO was full.
REQ-014 proto_err  out  1  sticky: illegal prefix sequence seen.
REQ-015 rel_cnt  out  8  count of decoded break events, wraps 0xFF->0x00.
REQ-016 caps_lock  out  1  caps-lock toggle state.

Function
REQ-017 The decoder SHALL be an FSM with states IDLE, E0, F0, E0F0, SKIP; it advances only on cycles with in_valid=1.
REQ-018 IDLE: 0xE0->E0; 0xF0->F0; 0xE1->SKIP with skip counter=7; 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF SHALL be discarded (stay IDLE); any other byte -> push {code, ext=0, brk=0}, stay IDLE.
REQ-019 E0: 0xF0->E0F0; 0xE0 -> stay E0 (no error); 0xE1 or 0xF0-free status byte treated as code; any other byte -> push {code, ext=1, brk=0}, ->IDLE.
REQ-020 F0: 0xE0, 0xE1 or 0xF0 -> set proto_err, discard, ->IDLE; else push {code, ext=0, brk=1}, ->IDLE.
REQ-021 E0F0: 0xE0, 0xE1 or 0xF0 -> set proto_err, discard, ->IDLE; else push {code, ext=1, brk=1}, ->IDLE.
REQ-022 SKIP: each in_valid byte decrements skip counter and is discarded; the byte that brings the counter to 0 returns FSM to IDLE (Pause sequence E1 14 77 E1 F0 14 F0 77 fully absorbed, no events).
REQ-023 Push latency: event decoded from in_byte in cycle N SHALL be visible at the FIFO head (if FIFO was empty) in cycle N+1.
REQ-024 Pop: when ev_valid=1 and ev_pop=1 the head SHALL advance at that posedge; ev_pop with ev_valid=0 SHALL be ignored.
REQ-025 Simultaneous push and pop SHALL both take effect; ev_count unchanged; allowed when full (no drop).
REQ-026 Push when full without pop SHALL drop the event, leave FIFO contents unchanged, and set overflow.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; ev_count SHALL range 0..DEPTH exactly.
REQ-028 rel_cnt SHALL increment on every decoded break event, including ones dropped by overflow.
REQ-029 caps_lock SHALL toggle on a decoded non-extended make of 0x58 only when caps_held=0; caps_held set by that make, cleared by non-extended break of 0x58 (typematic repeats ignored).
REQ-030 clr_err SHALL clear overflow and proto_err next cycle; if a set condition occurs in the same cycle, set wins.
REQ-031 ev_code/ev_ext/ev_break SHALL be 0 when ev_valid=0.

Reset
REQ-032 rst=1 at posedge SHALL force FSM=IDLE, skip counter=0, FIFO empty (ev_valid=0, ev_count=0), overflow=0, proto_err=0, rel_cnt=0, caps_lock=0, caps_held=0.
REQ-033 rst mid-sequence (e.g. after E0) SHALL discard the partial prefix; in_valid in the reset cycle SHALL be ignored.

Verification
REQ-034 Bytes 1C, F0, 1C -> events {1C,ext0,brk0},{1C,ext0,brk1}; rel_cnt=1; ev_count=2.
REQ-035 Bytes E0, 75, E0, F0, 75 -> {75,ext1,brk0},{75,ext1,brk1}; first event ev_valid one cycle after the 75 strobe.
REQ-036 Bytes E1 14 77 E1 F0 14 F0 77 then 1C -> only event {1C,0,0}; FSM IDLE; proto_err=0.
REQ-037 Nine make codes with no pop (DEPTH=8) -> ev_count=8, overflow=1, ninth dropped; push+pop in one cycle when full -> ev_count stays 8, overflow unchanged by that push.
REQ-038 Bytes 58, 58, 58, F0 58, 58 -> caps_lock 0->1 on first 58, unchanged by repeats, ->0 after final 58; F0 F0 -> proto_err=1, clr_err -> 0.
REQ-039 E0 strobe then rst, then 75 -> single event {75,ext0,brk0}.

Source files
------------

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard scancode decoder with an event FIFO.
// Prefix bytes (E0, F0, E1 Pause sequence) are folded into one event per key.
// Each event is {code, ext, brk} and is queued for the consumer.
// Sticky error flags, a release counter and caps-lock tracking sit beside the queue.
module ps2_kbd_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    input  logic       ev_pop,
    input  logic       clr_err,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic [4:0] ev_count,
    output logic       overflow,
    output logic       proto_err,
    output logic [7:0] rel_cnt,
    output logic       caps_lock
);

    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0,
        ST_SKIP
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic [9:0]    fifo_mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          proto_err_q, proto_err_d;
    logic [7:0]    rel_cnt_q, rel_cnt_d;
    logic          caps_lock_q, caps_lock_d;
    logic          caps_held_q, caps_held_d;

    logic          dec_push;
    logic          dec_ext;
    logic          dec_brk;
    logic          proto_set;
    logic          is_status;
    logic          is_prefix;
    logic          do_push;
    logic          do_pop;
    logic          drop;
    logic [9:0]    head;

    // Bytes the keyboard sends as status/acks, never as key codes
    always_comb begin
        is_status = (in_byte == 8'h00) || (in_byte == 8'hAA) || (in_byte == 8'hEE) ||
                    (in_byte == 8'hFA) || (in_byte == 8'hFE) || (in_byte == 8'hFF);
        is_prefix = (in_byte == 8'hE0) || (in_byte == 8'hE1) || (in_byte == 8'hF0);
    end

    // Prefix decoder: walks the byte stream and emits at most one event per strobe
    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        dec_push  = 1'b0;
        dec_ext   = 1'b0;
        dec_brk   = 1'b0;
        proto_set = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_byte == 8'hE0) begin
                        state_d = ST_E0;
                    end else if (in_byte == 8'hF0) begin
                        state_d = ST_F0;
                    end else if (in_byte == 8'hE1) begin
                        state_d = ST_SKIP;
                        skip_d  = 3'd7;
                    end else if (!is_status) begin
                        dec_push = 1'b1;
                    end
                end
                ST_E0: begin
                    if (in_byte == 8'hF0) begin
                        state_d = ST_E0F0;
                    end else if (in_byte != 8'hE0) begin
                        dec_push = 1'b1;
                        dec_ext  = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_F0: begin
                    state_d = ST_IDLE;
                    if (is_prefix) begin
                        proto_set = 1'b1;
                    end else begin
                        dec_push = 1'b1;
                        dec_brk  = 1'b1;
                    end
                end
                ST_E0F0: begin
                    state_d = ST_IDLE;
                    if (is_prefix) begin
                        proto_set = 1'b1;
                    end else begin
                        dec_push = 1'b1;
                        dec_ext  = 1'b1;
                        dec_brk  = 1'b1;
                    end
                end
                ST_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) begin
                        skip_d  = 3'd0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    skip_d  = 3'd0;
                end
            endcase
        end
    end

    // Queue bookkeeping; a pop frees the slot so a full queue still accepts a push
    always_comb begin
        do_pop      = ev_pop && (count_q != 5'd0);
        do_push     = dec_push && ((count_q != DEPTH_C) || do_pop);
        drop        = dec_push && !do_push;
        wr_ptr_d    = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = do_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d     = count_q + {4'd0, do_push} - {4'd0, do_pop};
        overflow_d  = drop ? 1'b1 : (clr_err ? 1'b0 : overflow_q);
        proto_err_d = proto_set ? 1'b1 : (clr_err ? 1'b0 : proto_err_q);
        rel_cnt_d   = rel_cnt_q + {7'd0, dec_push && dec_brk};
    end

    // Caps-lock toggles once per physical press; typematic repeats keep caps_held set
    always_comb begin
        caps_lock_d = caps_lock_q;
        caps_held_d = caps_held_q;
        if (dec_push && !dec_ext && (in_byte == 8'h58)) begin
            if (dec_brk) begin
                caps_held_d = 1'b0;
            end else begin
                caps_held_d = 1'b1;
                if (!caps_held_q) begin
                    caps_lock_d = !caps_lock_q;
                end
            end
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            skip_q      <= 3'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= 5'd0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
            rel_cnt_q   <= 8'd0;
            caps_lock_q <= 1'b0;
            caps_held_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
            rel_cnt_q   <= rel_cnt_d;
            caps_lock_q <= caps_lock_d;
            caps_held_q <= caps_held_d;
        end
    end

    // Event storage; contents need no reset because count_q gates visibility
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            fifo_mem_q[wr_ptr_q] <= {in_byte, dec_ext, dec_brk};
        end
    end

    // Head presentation, forced to zero while the queue is empty
    always_comb begin
        head      = fifo_mem_q[rd_ptr_q];
        ev_valid  = (count_q != 5'd0);
        ev_code   = ev_valid ? head[9:2] : 8'h00;
        ev_ext    = ev_valid && head[1];
        ev_break  = ev_valid && head[0];
        ev_count  = count_q;
        overflow  = overflow_q;
        proto_err = proto_err_q;
        rel_cnt   = rel_cnt_q;
        caps_lock = caps_lock_q;
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: hand-computed expectations after each step.
module tb_ps2_kbd_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       ev_pop = 1'b0;
    logic       clr_err = 1'b0;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic [4:0] ev_count;
    logic       overflow;
    logic       proto_err;
    logic [7:0] rel_cnt;
    logic       caps_lock;

    int checks = 0;
    int errors = 0;

    ps2_kbd_ctrl #(.DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .ev_pop    (ev_pop),
        .clr_err   (clr_err),
        .ev_valid  (ev_valid),
        .ev_code   (ev_code),
        .ev_ext    (ev_ext),
        .ev_break  (ev_break),
        .ev_count  (ev_count),
        .overflow  (overflow),
        .proto_err (proto_err),
        .rel_cnt   (rel_cnt),
        .caps_lock (caps_lock)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strobe one received byte for a single cycle
    task automatic applyStimulus(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        step();
        in_valid = 1'b0;
        in_byte  = 8'h00;
    endtask

    task automatic pop_one();
        ev_pop = 1'b1;
        step();
        ev_pop = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [7:0] code,
                              input logic ext, input logic brk);
        checkOutput({tag, "_valid"}, 8'(ev_valid), 8'h01);
        checkOutput({tag, "_code"},  ev_code,      code);
        checkOutput({tag, "_ext"},   8'(ev_ext),   8'(ext));
        checkOutput({tag, "_brk"},   8'(ev_break), 8'(brk));
    endtask

    initial begin
        $display("[TB] start");

        // Reset with a strobe present; it must be ignored
        in_valid = 1'b1;
        in_byte  = 8'h1C;
        step();
        step();
        in_valid = 1'b0;
        rst      = 1'b0;
        checkOutput("rst_valid", 8'(ev_valid), 8'h00);
        checkOutput("rst_count", 8'(ev_count), 8'h00);
        checkOutput("rst_code", ev_code, 8'h00);
        checkOutput("rst_ovf", 8'(overflow), 8'h00);
        checkOutput("rst_perr", 8'(proto_err), 8'h00);
        checkOutput("rst_rel", rel_cnt, 8'h00);
        checkOutput("rst_caps", 8'(caps_lock), 8'h00);

        // Make and break of 1C
        applyStimulus(8'h1C);
        check_head("mk1c", 8'h1C, 1'b0, 1'b0);
        applyStimulus(8'hF0);
        applyStimulus(8'h1C);
        checkOutput("seq1_count", 8'(ev_count), 8'h02);
        checkOutput("seq1_rel", rel_cnt, 8'h01);
        pop_one();
        check_head("brk1c", 8'h1C, 1'b0, 1'b1);
        pop_one();
        checkOutput("seq1_empty", 8'(ev_valid), 8'h00);
        checkOutput("seq1_zero_code", ev_code, 8'h00);

        // Extended make/break of 75, event visible right after the 75 strobe
        applyStimulus(8'hE0);
        checkOutput("e0_no_event", 8'(ev_valid), 8'h00);
        applyStimulus(8'h75);
        check_head("mk75", 8'h75, 1'b1, 1'b0);
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        applyStimulus(8'h75);
        checkOutput("seq2_count", 8'(ev_count), 8'h02);
        checkOutput("seq2_rel", rel_cnt, 8'h02);
        pop_one();
        check_head("brk75", 8'h75, 1'b1, 1'b1);
        pop_one();

        // Pause sequence is absorbed, then 1C decodes normally
        applyStimulus(8'hE1);
        applyStimulus(8'h14);
        applyStimulus(8'h77);
        applyStimulus(8'hE1);
        applyStimulus(8'hF0);
        applyStimulus(8'h14);
        applyStimulus(8'hF0);
        applyStimulus(8'h77);
        checkOutput("pause_count", 8'(ev_count), 8'h00);
        checkOutput("pause_perr", 8'(proto_err), 8'h00);
        applyStimulus(8'h1C);
        checkOutput("pause_after_count", 8'(ev_count), 8'h01);
        check_head("pause_1c", 8'h1C, 1'b0, 1'b0);
        pop_one();

        // Status bytes are dropped in IDLE
        applyStimulus(8'hAA);
        applyStimulus(8'hFA);
        checkOutput("status_drop", 8'(ev_count), 8'h00);

        // Fill to eight, ninth make is dropped
        for (int i = 0; i < 9; i++) begin
            applyStimulus(8'h10 + 8'(i));
            if (i == 7) begin
                checkOutput("full_count", 8'(ev_count), 8'h08);
                checkOutput("full_no_ovf", 8'(overflow), 8'h00);
            end
        end
        checkOutput("ovf_count", 8'(ev_count), 8'h08);
        checkOutput("ovf_set", 8'(overflow), 8'h01);
        checkOutput("ovf_head", ev_code, 8'h10);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checkOutput("ovf_clr", 8'(overflow), 8'h00);

        // Push and pop together while full
        in_valid = 1'b1;
        in_byte  = 8'h20;
        ev_pop   = 1'b1;
        step();
        in_valid = 1'b0;
        ev_pop   = 1'b0;
        checkOutput("pp_count", 8'(ev_count), 8'h08);
        checkOutput("pp_ovf", 8'(overflow), 8'h00);
        checkOutput("pp_head", ev_code, 8'h11);
        for (int i = 0; i < 7; i++) begin
            pop_one();
            checkOutput("drain_code", ev_code, (i == 6) ? 8'h20 : 8'h12 + 8'(i));
        end
        pop_one();
        checkOutput("drain_empty", 8'(ev_count), 8'h00);
        ev_pop = 1'b1;
        step();
        ev_pop = 1'b0;
        checkOutput("pop_empty_ignored", 8'(ev_count), 8'h00);

        // Caps lock toggles once per press, repeats ignored
        applyStimulus(8'h58);
        checkOutput("caps_first", 8'(caps_lock), 8'h01);
        applyStimulus(8'h58);
        applyStimulus(8'h58);
        checkOutput("caps_repeat", 8'(caps_lock), 8'h01);
        applyStimulus(8'hF0);
        applyStimulus(8'h58);
        checkOutput("caps_release", 8'(caps_lock), 8'h01);
        applyStimulus(8'h58);
        checkOutput("caps_second", 8'(caps_lock), 8'h00);
        checkOutput("caps_rel", rel_cnt, 8'h03);
        checkOutput("caps_count", 8'(ev_count), 8'h05);
        for (int i = 0; i < 5; i++) pop_one();

        // Illegal F0 F0 sets proto_err; clr_err clears it; set wins over clear
        applyStimulus(8'hF0);
        applyStimulus(8'hF0);
        checkOutput("perr_set", 8'(proto_err), 8'h01);
        checkOutput("perr_no_event", 8'(ev_count), 8'h00);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checkOutput("perr_clr", 8'(proto_err), 8'h00);
        applyStimulus(8'hF0);
        clr_err = 1'b1;
        applyStimulus(8'hE0);
        clr_err = 1'b0;
        checkOutput("perr_set_wins", 8'(proto_err), 8'h01);

        // Reset after an E0 discards the prefix
        applyStimulus(8'hE0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("rst2_perr", 8'(proto_err), 8'h00);
        checkOutput("rst2_rel", rel_cnt, 8'h00);
        applyStimulus(8'h75);
        check_head("rst2_75", 8'h75, 1'b0, 1'b0);
        checkOutput("rst2_count", 8'(ev_count), 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
